// File: rtl/prio_enc_pkg.sv
// -----------------------------------------------------------------------------
// prio_enc_pkg
// Shared types and helpers for the prio_enc_drain slice.
//   state_t      : drain FSM states (IDLE, DRAIN)
//   idx_w(n)     : index width for an n-bit request vector (at least 1)
//   cnt_w(n)     : width able to hold a count of 0..n pending bits
//   popcount(v)  : number of set bits in a (zero-extended) 64-bit vector
// Optional feature macro used by this slice: PRIO_ENC_RR_EN (rotating priority).
// -----------------------------------------------------------------------------
package prio_enc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/prio_sel.sv
// -----------------------------------------------------------------------------
// prio_sel
// Purely combinational N-bit priority selector. The search starts at bit
// 'start' and descends with wrap-around (start, start-1, ..., 0, N-1, ...);
// the first set bit found wins. Tying start to N-1 gives plain
// highest-index-first priority.
// Ports:
//   vec   in  N      candidate bits
//   start in  IDX_W  first position examined
//   idx   out IDX_W  winning position (0 when nothing is set)
//   any   out 1      at least one bit of vec is set
// -----------------------------------------------------------------------------
module prio_sel
    import prio_enc_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int               pos;
        logic [IDX_W-1:0] pos_idx;
        idx     = '0;
        any     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int off = 0; off < N; off++) begin
            // Walk downwards from start, folding negative positions back
            // to the top of the vector.
            pos = int'(start) - off;
            if (pos < 0) begin
                pos = pos + N;
            end
            pos_idx = IDX_W'(pos);
            if (!any && (pos < N) && vec[pos_idx]) begin
                any = 1'b1;
                idx = pos_idx;
            end
        end
    end

endmodule

// File: rtl/prio_enc_drain.sv
// -----------------------------------------------------------------------------
// prio_enc_drain
// Registered priority encoder: captures an N-bit request vector and drains it
// one index per accepted output beat, highest-priority set bit first.
// Build option: define PRIO_ENC_RR_EN for rotating priority (search starts at
// a pointer that moves just below the last-served index and persists across
// vectors). Without it, the highest set index always wins.
// Ports:
//   clk        in  1      rising-edge clock
//   rst_n      in  1      asynchronous active-low reset
//   in_valid   in  1      request vector valid
//   in_ready   out 1      block can capture a vector (IDLE)
//   in_vec     in  N      request vector, bit k = request k
//   out_valid  out 1      out_idx valid (DRAIN)
//   out_ready  in  1      consumer accepts out_idx
//   out_idx    out IDX_W  index of the current highest-priority pending bit
//   out_last   out 1      current beat is the final pending bit
//   pend_cnt   out CNT_W  number of pending bits
//   zero_err   out 1      one-cycle pulse after an all-zero vector is accepted
//   dbg_state  out 1      current FSM state
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holds valid and its payload until that edge; ready never
// depends combinationally on valid. Here in_ready and out_valid decode the
// registered state only, and the out_* payload is a function of registered
// pend/ptr only, so it stays stable across stalls.
// -----------------------------------------------------------------------------
module prio_enc_drain
    import prio_enc_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = idx_w(N),
    localparam int CNT_W = cnt_w(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             zero_err,
    output state_t           dbg_state
);

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(N - 1);

    state_t           state;
    logic [N-1:0]     pend;
    logic [IDX_W-1:0] sel_start;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;

`ifdef PRIO_ENC_RR_EN
    logic [IDX_W-1:0] ptr;
    assign sel_start = ptr;
`else
    assign sel_start = TOP_IDX;
`endif

    prio_sel #(
        .N (N)
    ) u_sel (
        .vec   (pend),
        .start (sel_start),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DRAIN);
    // With pend empty the selector reports index 0, which is the reset value.
    assign out_idx   = sel_any ? sel_idx : '0;
    assign pend_cnt  = CNT_W'(popcount(64'(pend)));
    assign out_last  = (pend_cnt == CNT_W'(1));
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= '0;
            zero_err <= 1'b0;
`ifdef PRIO_ENC_RR_EN
            ptr      <= TOP_IDX;
`endif
        end else begin
            zero_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_vec != '0) begin
                            pend  <= in_vec;
                            state <= DRAIN;
                        end else begin
                            // Nothing to drain: flag it and stay ready.
                            zero_err <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        pend[out_idx] <= 1'b0;
`ifdef PRIO_ENC_RR_EN
                        // The served index becomes the lowest priority.
                        ptr <= (out_idx == '0) ? TOP_IDX : (out_idx - 1'b1);
`endif
                        if (out_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    pend  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_enc_drain.sv
// -----------------------------------------------------------------------------
// tb_prio_enc_drain
// Self-checking bench for prio_enc_drain with N=8. The expected drain order of
// each captured vector is computed up front from the priority rules and kept
// in exp_q; every cycle of the drain is checked against the head of exp_q.
// Works in both the default build and with PRIO_ENC_RR_EN defined.
// -----------------------------------------------------------------------------
module tb_prio_enc_drain;
    import prio_enc_pkg::*;

    localparam int N = 8;
    localparam int W = 3;
    localparam int C = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic [C-1:0] pend_cnt;
    logic         zero_err;
    state_t       dbg_state;

    int n_tests;
    int n_fail;
    int last_beats;
    int m_ptr;
    logic [W-1:0] exp_q[$];

    prio_enc_drain #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .pend_cnt  (pend_cnt),
        .zero_err  (zero_err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected service order for a captured vector. In the fixed build the
    // highest set index goes first. In the rotating build the search begins at
    // the model pointer and descends with wrap; each served index k moves the
    // pointer to k-1 (or N-1 after index 0).
    task automatic model_load(input logic [N-1:0] v);
        logic [N-1:0] rem;
        rem = v;
`ifdef PRIO_ENC_RR_EN
        while (rem != '0) begin
            int found;
            found = -1;
            for (int off = 0; off < N && found < 0; off++) begin
                int p;
                p = (m_ptr - off + N) % N;
                if (rem[p]) found = p;
            end
            exp_q.push_back(W'(found));
            rem[found] = 1'b0;
            m_ptr = (found == 0) ? N - 1 : found - 1;
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (rem[i]) exp_q.push_back(W'(i));
        end
`endif
    endtask

    // ---------------- driver tasks ----------------
    // Called on a falling edge with the DUT idle.
    task automatic send_vec(input logic [N-1:0] v);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        check("state_idle", 32'(dbg_state), 32'(IDLE));
        in_valid  = 1'b1;
        in_vec    = v;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_vec   = N'($urandom);
        if (v == '0) begin
            check("zero_err_pulse", 32'(zero_err), 32'd1);
            check("zero_no_out_valid", 32'(out_valid), 32'd0);
            check("zero_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            check("zero_err_clear", 32'(zero_err), 32'd0);
            check("zero_no_out_valid2", 32'(out_valid), 32'd0);
        end else begin
            check("no_zero_err", 32'(zero_err), 32'd0);
            model_load(v);
        end
    endtask

    // mode 0: out_ready always high, 1: toggle 1,0,1,..., 2: random
    task automatic drain(input int mode);
        int budget;
        int beats;
        bit rdy;
        bit tog;
        budget = 0;
        beats  = 0;
        tog    = 1'b1;
        while (exp_q.size() != 0 && budget < 4 * N + 8) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("in_ready_drain", 32'(in_ready), 32'd0);
            check("out_idx", 32'(out_idx), 32'(exp_q[0]));
            check("out_last", 32'(out_last), 32'(exp_q.size() == 1));
            check("pend_cnt", 32'(pend_cnt), 32'(exp_q.size()));
            case (mode)
                0:       rdy = 1'b1;
                1:       begin rdy = tog; tog = ~tog; end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            // Input side is ignored while draining.
            in_valid  = 1'($urandom_range(0, 1));
            in_vec    = N'($urandom);
            @(negedge clk);
            if (rdy) begin
                void'(exp_q.pop_front());
                beats++;
            end
            budget++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("end_out_valid", 32'(out_valid), 32'd0);
        check("end_in_ready", 32'(in_ready), 32'd1);
        check("end_pend_cnt", 32'(pend_cnt), 32'd0);
        last_beats = beats;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_tests    = 0;
        n_fail     = 0;
        last_beats = 0;
        m_ptr      = N - 1;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_vec     = '0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_pend_cnt", 32'(pend_cnt), 32'd0);
        check("rst_zero_err", 32'(zero_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single bit
        send_vec(8'b0000_1000);
        drain(0);
        check("single_beats", 32'(last_beats), 32'd1);

        // two bits
        send_vec(8'b0010_0001);
        drain(0);
        check("two_beats", 32'(last_beats), 32'd2);

        // all ones with stalls
        send_vec(8'hFF);
        drain(1);
        check("ff_beats", 32'(last_beats), 32'd8);

        // all-zero vector
        send_vec(8'h00);

        // asynchronous reset mid-drain after two beats
        send_vec(8'hF0);
        for (int b = 0; b < 2; b++) begin
            check("rst_pre_idx", 32'(out_idx), 32'(exp_q[0]));
            out_ready = 1'b1;
            @(negedge clk);
            void'(exp_q.pop_front());
        end
        out_ready = 1'b0;
        check("rst_pre_cnt", 32'(pend_cnt), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_pend_cnt", 32'(pend_cnt), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        m_ptr = N - 1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_vec(8'h01);
        check("post_rst_idx", 32'(out_idx), 32'd0);
        drain(0);

        // pointer-sensitive sequences (fixed order in the default build)
        send_vec(8'b1000_0001);
        drain(0);
        send_vec(8'b1000_0001);
        drain(0);
        send_vec(8'b0011_1000);
        drain(2);
        send_vec(8'b1000_0100);
        drain(0);
        send_vec(8'hFF);
        drain(2);
        send_vec(8'b1000_0100);
        drain(0);

        // random traffic
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] v;
            v = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
            send_vec(v);
            if (v != '0) drain(2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
